// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - colour codes, filter states and small helpers shared by the colour path
package color_pkg;

  typedef logic [1:0] color_code_t;

  localparam color_code_t COL_NONE  = 2'd0;
  localparam color_code_t COL_RED   = 2'd1;
  localparam color_code_t COL_BLUE  = 2'd2;
  localparam color_code_t COL_GREEN = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QUAL   = 3'd1,
    REPORT = 3'd2,
    HOLD   = 3'd3,
    CLEAR  = 3'd4
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/color_decode.sv
// rtl/color_decode.sv - one-hot sensor vector to colour code, NONE for any invalid pattern
module color_decode
  import color_pkg::*;
(
  input  logic [2:0]  i_color,
  output color_code_t o_code
);

  // Only a clean single-bit reading names a colour; zero and multi-hot are both "nothing seen"
  always_comb begin
    o_code = COL_NONE;
    case (i_color)
      3'b001:  o_code = COL_RED;
      3'b010:  o_code = COL_BLUE;
      3'b100:  o_code = COL_GREEN;
      default: o_code = COL_NONE;
    endcase
  end

endmodule

// File: rtl/color_event_filter.sv
// rtl/color_event_filter.sv - qualifies stable colours, emits one event per object, keeps tallies
module color_event_filter
  import color_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 600000,
  parameter int unsigned CLEAR_CYCLES  = 300000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] color,
  output logic       evt_valid,
  output logic [1:0] evt_color,
  input  logic       evt_ready,
  output logic [7:0] cnt_red,
  output logic [7:0] cnt_blue,
  output logic [7:0] cnt_green,
  output logic       busy
);

  localparam int unsigned MAX_CYCLES = max_u(STABLE_CYCLES, CLEAR_CYCLES);
  localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] L_ONE    = TW'(1);
  localparam logic [TW-1:0] L_STABLE = TW'(STABLE_CYCLES);
  localparam logic [TW-1:0] L_CLEAR  = TW'(CLEAR_CYCLES);

  // A fresh candidate already counts one sample, so a one-sample window skips straight ahead
  localparam state_t S_QUAL_ENTRY  = (STABLE_CYCLES == 1) ? REPORT : QUAL;
  localparam state_t S_CLEAR_ENTRY = (CLEAR_CYCLES == 1) ? IDLE : CLEAR;

  color_code_t   w_code;
  state_t        r_state;
  state_t        w_state_nxt;
  color_code_t   r_cand;
  color_code_t   w_cand_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;
  logic [TW-1:0] w_tmr_inc;
  logic          w_accept;

  logic          r_evt_valid;
  color_code_t   r_evt_color;
  logic          r_busy;
  logic          w_evt_valid_nxt;
  color_code_t   w_evt_color_nxt;
  logic          w_busy_nxt;

  logic [7:0]    r_cnt_red;
  logic [7:0]    r_cnt_blue;
  logic [7:0]    r_cnt_green;

  color_decode u_decode (
    .i_color (color),
    .o_code  (w_code)
  );

  // The timer is below its terminal value whenever it is incremented, so this never wraps
  assign w_tmr_inc = r_tmr + L_ONE;
  assign w_accept  = (r_state == REPORT) && evt_ready;

  // State, candidate and timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cand  <= COL_NONE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Next-state rules: qualify, wait for the consumer, then wait for the object to leave
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      IDLE: begin
        if (w_code != COL_NONE) begin
          w_cand_nxt  = w_code;
          w_tmr_nxt   = L_ONE;
          w_state_nxt = S_QUAL_ENTRY;
        end
      end
      QUAL: begin
        if (w_code == COL_NONE) begin
          w_state_nxt = IDLE;
        end else if (w_code == r_cand) begin
          w_tmr_nxt = w_tmr_inc;
          if (w_tmr_inc >= L_STABLE) begin
            w_state_nxt = REPORT;
          end
        end else begin
          w_cand_nxt  = w_code;
          w_tmr_nxt   = L_ONE;
          w_state_nxt = S_QUAL_ENTRY;
        end
      end
      REPORT: begin
        if (evt_ready) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_code == COL_NONE) begin
          w_tmr_nxt   = L_ONE;
          w_state_nxt = S_CLEAR_ENTRY;
        end else if (w_code != r_cand) begin
          w_cand_nxt  = w_code;
          w_tmr_nxt   = L_ONE;
          w_state_nxt = S_QUAL_ENTRY;
        end
      end
      CLEAR: begin
        if (w_code == COL_NONE) begin
          w_tmr_nxt = w_tmr_inc;
          if (w_tmr_inc >= L_CLEAR) begin
            w_state_nxt = IDLE;
          end
        end else if (w_code == r_cand) begin
          w_state_nxt = HOLD;
        end else begin
          w_cand_nxt  = w_code;
          w_tmr_nxt   = L_ONE;
          w_state_nxt = S_QUAL_ENTRY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output values derived from the upcoming state so the outputs themselves can be flops
  always_comb begin
    w_evt_valid_nxt = (w_state_nxt == REPORT);
    w_evt_color_nxt = (w_state_nxt == REPORT) ? w_cand_nxt : COL_NONE;
    w_busy_nxt      = (w_state_nxt != IDLE);
  end

  // Registered event and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_color <= COL_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_evt_valid <= w_evt_valid_nxt;
      r_evt_color <= w_evt_color_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Saturating per-colour tallies, bumped only on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_red   <= 8'd0;
      r_cnt_blue  <= 8'd0;
      r_cnt_green <= 8'd0;
    end else if (w_accept) begin
      case (r_cand)
        COL_RED:   if (r_cnt_red   != 8'hFF) r_cnt_red   <= r_cnt_red   + 8'd1;
        COL_BLUE:  if (r_cnt_blue  != 8'hFF) r_cnt_blue  <= r_cnt_blue  + 8'd1;
        COL_GREEN: if (r_cnt_green != 8'hFF) r_cnt_green <= r_cnt_green + 8'd1;
        default:   ;
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_color = r_evt_color;
  assign busy      = r_busy;
  assign cnt_red   = r_cnt_red;
  assign cnt_blue  = r_cnt_blue;
  assign cnt_green = r_cnt_green;

endmodule
